// File: rtl/ev_motor_ramp_ctrl.sv
// ev_motor_ramp_ctrl: pedal-driven EV speed controller with ramped speed, supervisory FSM and PWM drive
module ev_motor_ramp_ctrl #(
  parameter int IN_W       = 4,
  parameter int SPD_W      = 8,
  parameter int RAMP_DIV   = 4,
  parameter int RAMP_STEP  = 16,
  parameter int BRAKE_STEP = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             power_plc,
  input  logic             power_hmi,
  input  logic [IN_W-1:0]  accel,
  input  logic [IN_W-1:0]  brake,
  input  logic             estop,
  input  logic             fault_clr,
  output logic [SPD_W-1:0] speed,
  output logic             pwm,
  output logic [2:0]       state,
  output logic             fault,
  output logic             at_target
);
  typedef enum logic [2:0] {OFF = 3'd0, IDLE = 3'd1, RUN = 3'd2, BRAKE = 3'd3, FAULT = 3'd4} state_e;
  localparam int CW = RAMP_DIV > 1 ? $clog2(RAMP_DIV) : 1;
  state_e           state_q, state_d;
  logic [SPD_W-1:0] speed_q, speed_d, target, ramp, pwm_cnt_q, pwm_cnt_d;
  logic [CW-1:0]    tick_q;
  logic [SPD_W:0]   spd_x, tgt_x, step_x;
  logic [IN_W-1:0]  diff;
  logic             pwm_q, tick, system_on, go;
  assign system_on = power_plc | power_hmi;
  assign go        = accel > brake;
  assign diff      = accel - brake;
  assign tick      = tick_q == CW'(RAMP_DIV - 1);
  assign target    = (state_q == RUN && go) ? SPD_W'(diff) << (SPD_W - IN_W) : '0;
  assign spd_x     = {1'b0, speed_q};
  assign tgt_x     = {1'b0, target};
  assign step_x    = (SPD_W + 1)'(state_q == BRAKE ? BRAKE_STEP : RAMP_STEP);
  // One extra bit keeps the step arithmetic from wrapping; the result always lies between speed and target.
  assign ramp      = SPD_W'(tgt_x >= spd_x ? (tgt_x - spd_x <= step_x ? tgt_x : spd_x + step_x)
                                           : (spd_x - tgt_x <= step_x ? tgt_x : spd_x - step_x));
  assign pwm_cnt_d = pwm_cnt_q + SPD_W'(1);
  // Supervisory next state and speed: estop, then sticky fault, then power, then pedal-driven modes.
  always_comb begin
    state_d = state_q;
    speed_d = speed_q;
    if (estop) begin
      state_d = FAULT;
      speed_d = '0;
    end else if (state_q == FAULT) begin
      if (fault_clr && accel == '0) state_d = system_on ? IDLE : OFF;
    end else if (!system_on || state_q == OFF) begin
      state_d = system_on ? IDLE : OFF;
      speed_d = '0;
    end else if (state_q == IDLE) begin
      speed_d = '0;
      if (go) state_d = RUN;
    end else if (state_q == RUN || state_q == BRAKE) begin
      if (tick) speed_d = ramp;
      if (state_q == RUN && !go) state_d = BRAKE;
      else if (state_q == BRAKE && go) state_d = RUN;
      else if (state_q == BRAKE && speed_q == '0) state_d = IDLE;
    end else begin
      state_d = OFF;
      speed_d = '0;
    end
  end
  // All state advances only while enabled; pwm tracks the comparison of the registers it is loaded with.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= OFF;
      speed_q   <= '0;
      tick_q    <= '0;
      pwm_cnt_q <= '0;
      pwm_q     <= 1'b0;
    end else if (ena) begin
      state_q   <= state_d;
      speed_q   <= speed_d;
      tick_q    <= tick ? '0 : tick_q + CW'(1);
      pwm_cnt_q <= pwm_cnt_d;
      pwm_q     <= pwm_cnt_d < speed_d;
    end
  end
  assign speed     = speed_q;
  assign pwm       = pwm_q;
  assign state     = state_q;
  assign fault     = state_q == FAULT;
  assign at_target = speed_q == target;
endmodule

// File: tb/tb_ev_motor_ramp_ctrl.sv
// tb_ev_motor_ramp_ctrl: directed scenario tests for the EV motor ramp controller
module tb_ev_motor_ramp_ctrl;
  logic       clk = 1'b0;
  logic       rst_n, ena, power_plc, power_hmi, estop, fault_clr;
  logic [3:0] accel, brake;
  logic [7:0] speed;
  logic       pwm, fault, at_target;
  logic [2:0] state;
  logic       rst2_n, ena2, power2, estop2, fault_clr2;
  logic [2:0] accel2, brake2;
  logic [9:0] speed2;
  logic       pwm2, fault2, at_target2;
  logic [2:0] state2;
  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  ev_motor_ramp_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .power_plc(power_plc), .power_hmi(power_hmi),
    .accel(accel), .brake(brake), .estop(estop), .fault_clr(fault_clr),
    .speed(speed), .pwm(pwm), .state(state), .fault(fault), .at_target(at_target)
  );

  ev_motor_ramp_ctrl #(.IN_W(3), .SPD_W(10)) u_dut2 (
    .clk(clk), .rst_n(rst2_n), .ena(ena2), .power_plc(1'b0), .power_hmi(power2),
    .accel(accel2), .brake(brake2), .estop(estop2), .fault_clr(fault_clr2),
    .speed(speed2), .pwm(pwm2), .state(state2), .fault(fault2), .at_target(at_target2)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 0; ena = 1; power_plc = 0; power_hmi = 0; accel = 0; brake = 0; estop = 0; fault_clr = 0;
    rst2_n = 0; ena2 = 1; power2 = 0; accel2 = 0; brake2 = 0; estop2 = 0; fault_clr2 = 0;
    @(posedge clk); #2;
    compared++; if (state !== 3'd0) begin mismatched++; $display("FAIL reset_state: got %0d want 0", state); end
    compared++; if (speed !== 8'd0) begin mismatched++; $display("FAIL reset_speed: got %0d want 0", speed); end
    compared++; if (pwm !== 1'b0) begin mismatched++; $display("FAIL reset_pwm: got %b want 0", pwm); end
    compared++; if (fault !== 1'b0) begin mismatched++; $display("FAIL reset_fault: got %b want 0", fault); end
    compared++; if (at_target !== 1'b1) begin mismatched++; $display("FAIL reset_at_target: got %b want 1", at_target); end
    power_hmi = 1; accel = 9; brake = 1;
    rst_n = 1;
  endtask

  task automatic test_power_up;
    step(1);
    compared++; if (state !== 3'd1) begin mismatched++; $display("FAIL pu_idle: got %0d want 1", state); end
    step(1);
    compared++; if (state !== 3'd2) begin mismatched++; $display("FAIL pu_run: got %0d want 2", state); end
    compared++; if (speed !== 8'd0) begin mismatched++; $display("FAIL pu_run_speed: got %0d want 0", speed); end
    step(1);
    compared++; if (speed !== 8'd0) begin mismatched++; $display("FAIL pu_pre_tick: got %0d want 0", speed); end
    step(1);
    compared++; if (speed !== 8'd16) begin mismatched++; $display("FAIL pu_first_tick: got %0d want 16", speed); end
    for (int k = 2; k <= 8; k++) begin
      step(3);
      compared++; if (speed !== 8'(16 * (k - 1))) begin mismatched++; $display("FAIL pu_hold k=%0d: got %0d want %0d", k, speed, 16 * (k - 1)); end
      step(1);
      compared++; if (speed !== 8'(16 * k)) begin mismatched++; $display("FAIL pu_step k=%0d: got %0d want %0d", k, speed, 16 * k); end
      compared++; if (at_target !== (k == 8)) begin mismatched++; $display("FAIL pu_at_target k=%0d: got %b want %b", k, at_target, k == 8); end
    end
    step(4);
    compared++; if (speed !== 8'd128) begin mismatched++; $display("FAIL pu_saturate: got %0d want 128", speed); end
    compared++; if (state !== 3'd2) begin mismatched++; $display("FAIL pu_state_hold: got %0d want 2", state); end
  endtask

  task automatic test_brake;
    brake = 9;
    step(1);
    compared++; if (state !== 3'd3) begin mismatched++; $display("FAIL br_state: got %0d want 3", state); end
    compared++; if (speed !== 8'd128) begin mismatched++; $display("FAIL br_speed_held: got %0d want 128", speed); end
    step(3);
    compared++; if (speed !== 8'd96) begin mismatched++; $display("FAIL br_first: got %0d want 96", speed); end
    for (int k = 1; k <= 3; k++) begin
      step(4);
      compared++; if (speed !== 8'(96 - 32 * k)) begin mismatched++; $display("FAIL br_step k=%0d: got %0d want %0d", k, speed, 96 - 32 * k); end
    end
    compared++; if (state !== 3'd3) begin mismatched++; $display("FAIL br_still_brake: got %0d want 3", state); end
    step(1);
    compared++; if (state !== 3'd1) begin mismatched++; $display("FAIL br_to_idle: got %0d want 1", state); end
  endtask

  task automatic test_estop;
    brake = 1;
    step(1);
    compared++; if (state !== 3'd2) begin mismatched++; $display("FAIL es_run: got %0d want 2", state); end
    step(18);
    compared++; if (speed !== 8'd80) begin mismatched++; $display("FAIL es_speed80: got %0d want 80", speed); end
    estop = 1;
    step(1);
    compared++; if (state !== 3'd4) begin mismatched++; $display("FAIL es_fault_state: got %0d want 4", state); end
    compared++; if (fault !== 1'b1) begin mismatched++; $display("FAIL es_fault_flag: got %b want 1", fault); end
    compared++; if (speed !== 8'd0) begin mismatched++; $display("FAIL es_speed0: got %0d want 0", speed); end
    compared++; if (pwm !== 1'b0) begin mismatched++; $display("FAIL es_pwm0: got %b want 0", pwm); end
    fault_clr = 1; accel = 0;
    step(1);
    compared++; if (state !== 3'd4) begin mismatched++; $display("FAIL es_clr_during_estop: got %0d want 4", state); end
    estop = 0; accel = 3;
    step(1);
    compared++; if (state !== 3'd4) begin mismatched++; $display("FAIL es_clr_with_accel: got %0d want 4", state); end
    accel = 0; power_hmi = 0; power_plc = 1;
    step(1);
    compared++; if (state !== 3'd1) begin mismatched++; $display("FAIL es_clr_to_idle: got %0d want 1", state); end
    compared++; if (fault !== 1'b0) begin mismatched++; $display("FAIL es_fault_cleared: got %b want 0", fault); end
    fault_clr = 0;
  endtask

  task automatic test_power_loss;
    accel = 9; brake = 1;
    step(1);
    compared++; if (state !== 3'd2) begin mismatched++; $display("FAIL pl_run: got %0d want 2", state); end
    step(15);
    compared++; if (speed !== 8'd64) begin mismatched++; $display("FAIL pl_speed64: got %0d want 64", speed); end
    power_plc = 0;
    step(1);
    compared++; if (state !== 3'd0) begin mismatched++; $display("FAIL pl_off: got %0d want 0", state); end
    compared++; if (speed !== 8'd0) begin mismatched++; $display("FAIL pl_speed0: got %0d want 0", speed); end
    power_hmi = 1; accel = 5; brake = 5;
    step(1);
    compared++; if (state !== 3'd1) begin mismatched++; $display("FAIL pl_repower_idle: got %0d want 1", state); end
    step(1);
    compared++; if (state !== 3'd1) begin mismatched++; $display("FAIL pl_equal_pedals: got %0d want 1", state); end
    accel = 6;
    step(1);
    compared++; if (state !== 3'd2) begin mismatched++; $display("FAIL pl_partial_run: got %0d want 2", state); end
    compared++; if (at_target !== 1'b0) begin mismatched++; $display("FAIL pl_not_at_target: got %b want 0", at_target); end
    step(3);
    compared++; if (speed !== 8'd0) begin mismatched++; $display("FAIL pl_pre_tick: got %0d want 0", speed); end
    step(1);
    compared++; if (speed !== 8'd16) begin mismatched++; $display("FAIL pl_one_tick: got %0d want 16", speed); end
    compared++; if (at_target !== 1'b1) begin mismatched++; $display("FAIL pl_at_target: got %b want 1", at_target); end
    step(4);
    compared++; if (speed !== 8'd16) begin mismatched++; $display("FAIL pl_hold16: got %0d want 16", speed); end
  endtask

  task automatic test_pwm_freeze;
    int high;
    accel = 9; brake = 5;
    step(12);
    compared++; if (speed !== 8'd64) begin mismatched++; $display("FAIL pw_speed64: got %0d want 64", speed); end
    high = 0;
    for (int i = 0; i < 256; i++) begin
      step(1);
      high += int'(pwm);
    end
    compared++; if (high != 64) begin mismatched++; $display("FAIL pw_duty: got %0d want 64", high); end
    compared++; if (speed !== 8'd64) begin mismatched++; $display("FAIL pw_speed_steady: got %0d want 64", speed); end
    step(150);
    compared++; if (pwm !== 1'b1) begin mismatched++; $display("FAIL pw_pre_freeze: got %b want 1", pwm); end
    ena = 0; power_hmi = 0; brake = 15;
    step(20);
    compared++; if (state !== 3'd2) begin mismatched++; $display("FAIL fz_state: got %0d want 2", state); end
    compared++; if (speed !== 8'd64) begin mismatched++; $display("FAIL fz_speed: got %0d want 64", speed); end
    compared++; if (pwm !== 1'b1) begin mismatched++; $display("FAIL fz_pwm: got %b want 1", pwm); end
    power_hmi = 1; accel = 9; brake = 1; ena = 1;
    step(1);
    compared++; if (speed !== 8'd64) begin mismatched++; $display("FAIL fz_resume_no_tick: got %0d want 64", speed); end
    step(1);
    compared++; if (speed !== 8'd80) begin mismatched++; $display("FAIL fz_resume_tick: got %0d want 80", speed); end
    step(115);
    compared++; if (speed !== 8'd128) begin mismatched++; $display("FAIL fz_speed128: got %0d want 128", speed); end
    compared++; if (pwm !== 1'b1) begin mismatched++; $display("FAIL fz_pwm_cnt127: got %b want 1", pwm); end
    step(1);
    compared++; if (pwm !== 1'b0) begin mismatched++; $display("FAIL fz_pwm_cnt128: got %b want 0", pwm); end
  endtask

  task automatic test_async_reset;
    #2 rst_n = 0;
    #1;
    compared++; if (state !== 3'd0) begin mismatched++; $display("FAIL ar_state: got %0d want 0", state); end
    compared++; if (speed !== 8'd0) begin mismatched++; $display("FAIL ar_speed: got %0d want 0", speed); end
  endtask

  task automatic test_param_sweep;
    power2 = 1; accel2 = 7; brake2 = 0;
    rst2_n = 1;
    step(1);
    compared++; if (state2 !== 3'd1) begin mismatched++; $display("FAIL ps_idle: got %0d want 1", state2); end
    step(1);
    compared++; if (state2 !== 3'd2) begin mismatched++; $display("FAIL ps_run: got %0d want 2", state2); end
    step(2);
    compared++; if (speed2 !== 10'd16) begin mismatched++; $display("FAIL ps_first: got %0d want 16", speed2); end
    step(108);
    compared++; if (speed2 !== 10'd448) begin mismatched++; $display("FAIL ps_mid: got %0d want 448", speed2); end
    step(111);
    compared++; if (speed2 !== 10'd880) begin mismatched++; $display("FAIL ps_pre_final: got %0d want 880", speed2); end
    compared++; if (at_target2 !== 1'b0) begin mismatched++; $display("FAIL ps_not_target: got %b want 0", at_target2); end
    step(1);
    compared++; if (speed2 !== 10'd896) begin mismatched++; $display("FAIL ps_final: got %0d want 896", speed2); end
    compared++; if (at_target2 !== 1'b1) begin mismatched++; $display("FAIL ps_at_target: got %b want 1", at_target2); end
    step(4);
    compared++; if (speed2 !== 10'd896) begin mismatched++; $display("FAIL ps_no_overshoot: got %0d want 896", speed2); end
  endtask

  task automatic test_back_to_back;
    estop2 = 1; power2 = 0;
    step(1);
    compared++; if (state2 !== 3'd4) begin mismatched++; $display("FAIL bb_estop_powerloss: got %0d want 4", state2); end
    compared++; if (speed2 !== 10'd0) begin mismatched++; $display("FAIL bb_speed0: got %0d want 0", speed2); end
    compared++; if (fault2 !== 1'b1) begin mismatched++; $display("FAIL bb_fault: got %b want 1", fault2); end
    estop2 = 0; fault_clr2 = 1; accel2 = 0;
    step(1);
    compared++; if (state2 !== 3'd0) begin mismatched++; $display("FAIL bb_clr_to_off: got %0d want 0", state2); end
  endtask

  initial begin
    test_reset;
    test_power_up;
    test_brake;
    test_estop;
    test_power_loss;
    test_pwm_freeze;
    test_async_reset;
    test_param_sweep;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
